// File: rtl/power_select_fsm.sv
// Two-player power-selection controller: synchronises the pushbuttons, runs player 1 then
// player 2 through select/confirm turns with a timeout, and announces each confirmed power
// as a code on `state`.
module power_select_fsm #(
  parameter int unsigned ANNOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] iKEY_POWER,
  input  logic       iKEY_CONFIRM,
  input  logic       iSTART,
  output logic [3:0] state,
  output logic [1:0] oP1_POWER,
  output logic [1:0] oP2_POWER,
  output logic [1:0] oPENDING,
  output logic       oPENDING_VALID,
  output logic       oDONE
);

  localparam int unsigned AnnW = (ANNOUNCE_CYCLES > 1) ? $clog2(ANNOUNCE_CYCLES) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam logic [AnnW-1:0] AnnLoad = AnnW'(ANNOUNCE_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StP1Sel, StP1Ann, StP2Sel, StP2Ann, StDone
  } fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [3:0]      sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [1:0]      pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic [1:0]      p1_q, p1_d, p2_q, p2_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [AnnW-1:0] ann_q, ann_d;
  logic [3:0]      state_q, state_d;
  logic            done_q, done_d;

  logic [3:0] press;
  logic       pow_press, conf_press, tmo_hit, do_confirm;
  logic [1:0] press_power, conf_power;

  // Bit 3 is the confirm key; a press is a falling edge of the synchronised level.
  assign press       = prev_q & ~sync2_q;
  assign pow_press   = |press[2:0];
  assign conf_press  = press[3];
  // Lowest key index wins on simultaneous presses.
  assign press_power = press[0] ? 2'b00 : (press[1] ? 2'b01 : 2'b10);
  assign tmo_hit     = (tmo_q == TmoLast);
  // A same-cycle power press overrides the pending value; timeout falls back to invisibility.
  assign do_confirm  = (conf_press && (pow_press || pend_vld_q)) || tmo_hit;
  assign conf_power  = pow_press ? press_power : (pend_vld_q ? pend_q : 2'b00);

  // State register: all flops, synchronous reset releases the synchronisers to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= StIdle;
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      prev_q     <= 4'hF;
      pend_q     <= 2'b00;
      pend_vld_q <= 1'b0;
      p1_q       <= 2'b00;
      p2_q       <= 2'b00;
      tmo_q      <= '0;
      ann_q      <= '0;
      state_q    <= 4'b0000;
      done_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      tmo_q      <= tmo_d;
      ann_q      <= ann_d;
      state_q    <= state_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: key pipeline, turn sequencing, pending/confirm, timeout and announce.
  always_comb begin
    sync1_d    = {iKEY_CONFIRM, iKEY_POWER};
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    fsm_d      = fsm_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    tmo_d      = tmo_q;
    ann_d      = ann_q;
    case (fsm_q)
      StIdle: begin
        if (iSTART) fsm_d = StP1Sel;
      end
      StP1Sel, StP2Sel: begin
        if (pow_press) begin
          pend_d     = press_power;
          pend_vld_d = 1'b1;
        end
        if (do_confirm) begin
          if (fsm_q == StP1Sel) begin
            p1_d  = conf_power;
            fsm_d = StP1Ann;
          end else begin
            p2_d  = conf_power;
            fsm_d = StP2Ann;
          end
          pend_d     = 2'b00;
          pend_vld_d = 1'b0;
          ann_d      = AnnLoad;
          tmo_d      = '0;
        end else if (!tmo_hit) begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StP1Ann, StP2Ann: begin
        if (ann_q == '0) begin
          fsm_d = (fsm_q == StP1Ann) ? StP2Sel : StDone;
        end else begin
          ann_d = ann_q - AnnW'(1);
        end
      end
      StDone: ;
      default: fsm_d = StIdle;
    endcase
  end

  // Output logic: next `state` code and done flag, registered alongside the FSM.
  always_comb begin
    state_d = 4'b0000;
    done_d  = 1'b0;
    case (fsm_d)
      StIdle:  state_d = 4'b0000;
      StP1Sel: state_d = 4'b0001;
      StP1Ann: state_d = {2'b01, p1_d};
      StP2Sel: state_d = 4'b0010;
      StP2Ann: state_d = {2'b01, p2_d};
      StDone: begin
        state_d = 4'b1000;
        done_d  = 1'b1;
      end
      default: state_d = 4'b0000;
    endcase
  end

  assign state          = state_q;
  assign oP1_POWER      = p1_q;
  assign oP2_POWER      = p2_q;
  assign oPENDING       = pend_q;
  assign oPENDING_VALID = pend_vld_q;
  assign oDONE          = done_q;

endmodule

// File: doc/power_select_fsm.md
# power_select_fsm

Two-player power-selection controller that turns raw pushbutton presses into the 4-bit `state` code consumed by the downstream power display stage. It synchronises and edge-detects the keys, runs player 1 then player 2 through select/confirm turns with a timeout, and announces each confirmed power as a code pulse. Power codes are 4'b0100, 4'b0101 and 4'b0110, and each is always separated from the next by a non-power code.

## Interface
- `ANNOUNCE_CYCLES`, default 4: cycles a confirmed power code is held on `state`; must be ≥1.
- `TIMEOUT_CYCLES`, default 500_000_000: cycles allowed in a select turn before a forced confirm (10 s at 50 MHz); must be ≥2.
- `clk`  in  1: system clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `iKEY_POWER`  in  3: raw pushbuttons, active-low, asynchronous. Bit 0 = invisibility, bit 1 = flexibility, bit 2 = camouflage.
- `iKEY_CONFIRM`  in  1: raw confirm pushbutton, active-low, asynchronous.
- `iSTART`  in  1: level input; starts selection from IDLE.
- `state`  out  4: selection code, registered.
- `oP1_POWER`  out  2: player 1 confirmed power. 00 = invisibility, 01 = flexibility, 10 = camouflage.
- `oP2_POWER`  out  2: player 2 confirmed power, same encoding.
- `oPENDING`  out  2: currently highlighted, unconfirmed power.
- `oPENDING_VALID`  out  1: `oPENDING` holds a selection.
- `oDONE`  out  1: both players have confirmed.

## Operation
- **Key input path:** each key goes through a 2-FF synchroniser and a previous-value register. A press is the high-to-low transition of the synchronised signal and lasts one cycle.
- **FSM states and `state` codes:**
  - IDLE = 4'b0000
  - P1_SEL = 4'b0001
  - P1_ANN = power code
  - P2_SEL = 4'b0010
  - P2_ANN = power code
  - DONE = 4'b1000
- **Power code mapping:** power p maps to code 4'b01_pp (00→0100, 01→0101, 10→0110).
- **Transitions:**
  - IDLE → P1_SEL when `iSTART`=1.
  - P1_SEL → P1_ANN on confirm.
  - P1_ANN → P2_SEL after `ANNOUNCE_CYCLES`.
  - P2_SEL → P2_ANN on confirm.
  - P2_ANN → DONE after `ANNOUNCE_CYCLES`.
  - DONE is terminal until `rst`; `iSTART` is ignored there.
- **Power press in a SEL state:** the pending register is loaded and `oPENDING_VALID` is set. Presses outside SEL states are ignored.
- **Simultaneous power presses:** the lowest bit index wins.
- **Confirm:**
  - Valid only in a SEL state with a pending selection, or with a power press in the same cycle.
  - A power press in the same cycle as confirm wins: the new power is the one confirmed.
  - Confirm with nothing pending is ignored.
- **Effect of a confirm:**
  - The confirmed power is written to `oP1_POWER`/`oP2_POWER`.
  - The pending register is cleared and `oPENDING_VALID` goes to 0.
  - The announce counter is loaded.
- **Timeout:**
  - The counter clears on entry to each SEL state and increments every cycle in SEL.
  - At count `TIMEOUT_CYCLES`-1 a confirm is forced.
  - The forced confirm uses the pending power if valid, otherwise invisibility (00).
  - A user confirm in the same cycle takes precedence, and the result is identical.
- **Same power for both players:** allowed. The P2_SEL code (4'b0010) separates two identical power codes, so the downstream stage always sees a change on `state`.
- **Counter widths:** `$clog2` of each parameter, with no wrap. Each counter saturates and clears on state exit.

## Timing
- **Reset:** `rst` sampled high at edge r means that after edge r all outputs are 0, the FSM is in IDLE, the synchronisers are flushed to 1 (released), and the counters are 0. The same applies to a reset in any state, mid-turn or mid-announce.
- **Key latency:** raw key sampled low at edge k → press pulse during cycle k+1..k+2 → registered effect (pending, `state`, powers) visible after edge k+2.
- **Start latency:** `iSTART` high at edge s → `state`=0001 after edge s.
- **Announce length:** the power code is held exactly `ANNOUNCE_CYCLES` cycles, then the next SEL or DONE code appears.
- **`oDONE`:** goes to 1 in the same cycle `state` becomes 4'b1000.
- **Forced confirm:** the announce phase starts exactly `TIMEOUT_CYCLES` cycles after SEL entry.

## Test plan
1. **Reset, start, normal selection:**
   - Stimulus: reset; `iSTART`=1; P1 presses bit 1 and confirms; P2 presses bit 2 and confirms.
   - Required `state` sequence: 0000 → 0001 → 0101 (4 cycles) → 0010 → 0110 (4 cycles) → 1000.
   - Required outputs: `oP1_POWER`=01, `oP2_POWER`=10, `oDONE`=1.
2. **Same power, re-select, simultaneous presses:**
   - Both players pick bit 0: `state` 0100 → 0010 → 0100, with a 0010 gap of ≥1 cycle.
   - P1 presses bit 2, then bit 0, then confirms: confirmed power is 00.
   - Bits 1 and 2 pressed together: pending = 01.
3. **Timeout (`TIMEOUT_CYCLES`=10):**
   - No press in P1_SEL: after 10 cycles `state`=0100 and `oP1_POWER`=00.
   - Pending 10 with no confirm in P2_SEL: forced confirm gives `oP2_POWER`=10.
4. **Ignored events:**
   - Confirm with nothing pending: stays in SEL.
   - Presses in IDLE, ANN or DONE: outputs unchanged.
   - `iSTART` in DONE: stays at 1000.
5. **Same-cycle press and confirm:** pending = 00, then bit 2 and confirm pressed together → confirmed power is 10.
6. **Reset mid-operation:** `rst` asserted during P2_ANN → all outputs 0 and `state`=0000 next cycle; a subsequent start runs normally.
